pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-sequencing controller for the 8-bit MCU's program counter. It fetches each instruction, decodes its control class and drives the counter's `load_pc` / `inc_pc` / `pc_in` controls. It handles jumps, zero-conditional branches, call/return through an internal return-address stack, one level of interrupt entry, and halt. It sits between instruction memory and the program counter and is the only driver of the counter's control inputs.

## Interface
- `STACK_DEPTH`, default 4: return-address stack entries (power of two, ≥2).
- `IRQ_VECTOR`, default 8'hF0: PC value loaded on interrupt entry.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `pc_cur`  in  8: current program counter value.
- `mem_ready`  in  1: instruction memory has valid `instr` / `operand`.
- `instr`  in  8: opcode byte; the class is `instr[7:5]`.
- `operand`  in  8: target address byte, valid together with `instr`.
- `zero_flag`  in  1: ALU zero flag, sampled in DECODE.
- `irq`  in  1: level interrupt request.
- `fetch_req`  out  1: fetch request to instruction memory at `pc_cur`.
- `load_pc`  out  1: counter load strobe.
- `inc_pc`  out  1: counter increment strobe.
- `pc_in`  out  8: counter load value.
- `in_isr`  out  1: currently executing an interrupt handler.
- `halted`  out  1: in HALT state.
- `stack_err`  out  1: sticky stack overflow/underflow flag.

## Operation
- Reset values: state FETCH; all outputs 0; stack pointer `sp` = 0; stack contents don't-care.
- Opcode classes:
  - 000 SEQ (NOP/ALU): increment PC.
  - 001 JMP: load `operand`.
  - 010 JZ: load `operand` if the latched zero flag is 1, else increment.
  - 011 CALL: push `pc_cur+1` (mod 256), then load `operand`.
  - 100 RET: pop into `pc_in` and load.
  - 101 HALT: enter HALT.
  - 110 and 111: treated as SEQ.
- States:
  - **FETCH**: `fetch_req`=1. When `mem_ready`=1, latch `instr` and `operand`, then go to DECODE. Otherwise stay.
  - **DECODE**: latch `zero_flag` and select the action.
    - CALL with `sp`==STACK_DEPTH, or RET with `sp`==0: set `stack_err` and go to HALT.
    - HALT class: go to HALT.
    - Otherwise go to EXEC.
  - **EXEC**: assert exactly one of `load_pc` / `inc_pc` for one cycle, with `pc_in` valid when `load_pc`=1. Perform the push or pop on the same edge. Next state:
    - If `irq`=1, `in_isr`=0 and `sp`<STACK_DEPTH: go to IRQ.
    - Otherwise go to FETCH.
  - **IRQ**: push `pc_cur`, which already holds the post-EXEC next address. Drive `load_pc`=1 with `pc_in`=IRQ_VECTOR. Set `in_isr`=1, record `isr_sp` = `sp` before the push, then go to FETCH.
  - **HALT**: `halted`=1. All strobes stay 0. Exit only on `reset`.
- A RET whose pop returns `sp` to `isr_sp` clears `in_isr`. Nested CALL/RET inside the handler leave `in_isr` set.
- `irq` while `in_isr`=1 is ignored (no queuing).
- `irq` with a full stack is deferred: it is re-sampled in each EXEC and never raises an error.
- `load_pc` and `inc_pc` are never both 1.
- Address arithmetic wraps modulo 256: CALL at 8'hFF pushes 8'h00.

## Timing
- Minimum instruction latency is 3 cycles: FETCH (with `mem_ready` already 1), then DECODE, then EXEC. Each `mem_ready` wait cycle adds one cycle.
- Interrupt entry adds 1 cycle (IRQ state).
- `pc_cur` reflects an EXEC or IRQ update on the cycle after the strobe. IRQ therefore reads the updated value.
- `fetch_req` is high only in FETCH. `instr` and `operand` are ignored outside the `mem_ready` cycle in FETCH.
- Asynchronous `reset` mid-instruction: all state is cleared immediately and no strobe is emitted. `stack_err` clears only on `reset`.

## Structure
- Shared package (`mcu_pkg`):
  - opcode class constants (`OP_SEQ`, `OP_JMP`, `OP_JZ`, `OP_CALL`, `OP_RET`, `OP_HALT`);
  - state encoding;
  - `ADDR_W` = 8.
- One natural sub-module, `ret_stack`: a STACK_DEPTH×8 LIFO with `push`, `pop`, `full`, `empty` and `sp` outputs, synchronous write, combinational top-of-stack read.

## Test plan
- Sequential: reset, `mem_ready`=1, three SEQ instructions from PC 0 → one `inc_pc` pulse every 3 cycles, PC 0→1→2→3, `load_pc` never 1.
- Branches: JMP 8'h40 → `load_pc`=1 with `pc_in`=8'h40. JZ 8'h20 with `zero_flag`=0 → `inc_pc`. JZ 8'h20 with `zero_flag`=1 → load 8'h20.
- Call/return: CALL 8'h80 at PC 8'h10, then RET → push 8'h11 and load 8'h80; RET loads 8'h11 with `sp` back to 0. Also CALL at 8'hFF → pushes 8'h00.
- Stack limits:
  - Five nested CALLs (depth 4) → the fifth gives `stack_err`=1, `halted`=1 and no strobe.
  - RET from reset → `stack_err`=1.
- Interrupt:
  - `irq`=1 during EXEC of SEQ at PC 8'h05 → IRQ state pushes 8'h06 and loads 8'hF0, `in_isr`=1.
  - A second `irq` is ignored.
  - RET → PC 8'h06, `in_isr`=0.
- Stalls and reset: `mem_ready` low for 4 cycles → FETCH holds `fetch_req`=1 with no strobes. `reset` asserted in EXEC → all outputs 0 in the same cycle, state FETCH after release.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU instruction sequencer: address width,
// opcode class codes, sequencer state encoding and a stack fault helper.
package mcu_pkg;

  localparam int ADDR_W = 8;

  // Opcode classes, taken from instr[7:5]; 110 and 111 behave as SEQ.
  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  // Sequencer states.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_IRQ    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // A CALL into a full stack or a RET from an empty one is fatal.
  function automatic logic stack_fault(input logic [2:0] cls,
                                       input logic       full,
                                       input logic       empty);
    return ((cls == OP_CALL) && full) || ((cls == OP_RET) && empty);
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: synchronous push, combinational top-of-stack read.
// Pushes into a full stack and pops from an empty one are ignored; the
// sequencer traps those cases before they reach here.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     sp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = PTR_W + 1;
  localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0] SP_DEPTH = SP_W'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_reg;
  logic [SP_W-1:0] sp_dec;

  assign sp_dec = sp_reg - SP_ONE;
  assign full   = (sp_reg == SP_DEPTH);
  assign empty  = (sp_reg == '0);
  assign sp     = sp_reg;
  assign top    = mem[sp_dec[PTR_W-1:0]];

  // Storage write; contents need no reset since sp bounds every read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp_reg[PTR_W-1:0]] <= push_data;
    end
  end

  // Stack pointer tracks the number of valid entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SP_ONE;
    end else if (pop && !empty) begin
      sp_reg <= sp_dec;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: FETCH -> DECODE -> EXEC per instruction, with
// an optional IRQ entry cycle after EXEC and a terminal HALT state.
module pc_sequencer
  import mcu_pkg::*;
#(
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR  = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              mem_ready,
  input  logic [7:0]        instr,
  input  logic [ADDR_W-1:0] operand,
  input  logic              zero_flag,
  input  logic              irq,
  output logic              fetch_req,
  output logic              load_pc,
  output logic              inc_pc,
  output logic [ADDR_W-1:0] pc_in,
  output logic              in_isr,
  output logic              halted,
  output logic              stack_err
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0] SP_DEPTH = SP_W'(STACK_DEPTH);

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [2:0]        cls_reg;
  logic [ADDR_W-1:0] operand_reg;
  logic              zf_reg;
  logic              in_isr_reg;
  logic              stack_err_reg;
  logic [SP_W-1:0]   isr_sp_reg;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top;
  logic              full;
  logic              empty;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_after;

  logic              load;
  logic              inc;
  logic [ADDR_W-1:0] target;
  logic              isr_return;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (top),
    .full      (full),
    .empty     (empty),
    .sp        (sp)
  );

  // Action for the current cycle: counter strobes, load target, stack op.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_cur + 8'd1;
    load      = 1'b0;
    inc       = 1'b0;
    target    = '0;
    case (state_reg)
      ST_EXEC: begin
        case (cls_reg)
          OP_JMP: begin
            load   = 1'b1;
            target = operand_reg;
          end
          OP_JZ: begin
            if (zf_reg) begin
              load   = 1'b1;
              target = operand_reg;
            end else begin
              inc = 1'b1;
            end
          end
          OP_CALL: begin
            push   = 1'b1;
            load   = 1'b1;
            target = operand_reg;
          end
          OP_RET: begin
            pop    = 1'b1;
            load   = 1'b1;
            target = top;
          end
          OP_SEQ:  inc = 1'b1;
          default: inc = 1'b1;
        endcase
      end
      ST_IRQ: begin
        // pc_cur already holds the address after the interrupted instruction.
        push      = 1'b1;
        push_data = pc_cur;
        load      = 1'b1;
        target    = IRQ_VECTOR;
      end
      default: ;
    endcase
  end

  // Stack depth once this cycle's push/pop lands; gates interrupt entry so
  // the IRQ push can never overflow.
  always_comb begin
    sp_after = sp;
    if (push) begin
      sp_after = sp + SP_ONE;
    end else if (pop) begin
      sp_after = sp - SP_ONE;
    end
  end

  // Leaving the handler: the RET that brings sp back to the entry depth.
  assign isr_return = (state_reg == ST_EXEC) && (cls_reg == OP_RET) &&
                      in_isr_reg && ((sp - SP_ONE) == isr_sp_reg);

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (mem_ready) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (stack_fault(cls_reg, full, empty) || (cls_reg == OP_HALT)) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (irq && !in_isr_reg && (sp_after < SP_DEPTH)) begin
          state_next = ST_IRQ;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_IRQ:  state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // State, instruction latches, interrupt context and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_FETCH;
      cls_reg       <= OP_SEQ;
      operand_reg   <= '0;
      zf_reg        <= 1'b0;
      in_isr_reg    <= 1'b0;
      isr_sp_reg    <= '0;
      stack_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_FETCH) && mem_ready) begin
        cls_reg     <= instr[7:5];
        operand_reg <= operand;
      end
      if (state_reg == ST_DECODE) begin
        zf_reg <= zero_flag;
        if (stack_fault(cls_reg, full, empty)) begin
          stack_err_reg <= 1'b1;
        end
      end
      if (state_reg == ST_IRQ) begin
        in_isr_reg <= 1'b1;
        isr_sp_reg <= sp;
      end else if (isr_return) begin
        in_isr_reg <= 1'b0;
      end
    end
  end

  // fetch_req is forced low while reset is held so every output reads 0.
  assign fetch_req = (state_reg == ST_FETCH) && !reset;
  assign load_pc   = load;
  assign inc_pc    = inc;
  assign pc_in     = load ? target : '0;
  assign in_isr    = in_isr_reg;
  assign halted    = (state_reg == ST_HALT);
  assign stack_err = stack_err_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: a bench-side program counter and a
// small instruction memory close the loop around the sequencer.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic [7:0] pc_preset;
  logic       mem_ready;
  logic [7:0] instr;
  logic [7:0] operand;
  logic       zero_flag;
  logic       irq;
  logic       fetch_req;
  logic       load_pc;
  logic       inc_pc;
  logic [7:0] pc_in;
  logic       in_isr;
  logic       halted;
  logic       stack_err;

  logic [7:0] prog_instr [256];
  logic [7:0] prog_op    [256];

  int total;
  int bad;

  pc_sequencer #(
    .STACK_DEPTH (4),
    .IRQ_VECTOR  (8'hF0)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .pc_cur    (pc),
    .mem_ready (mem_ready),
    .instr     (instr),
    .operand   (operand),
    .zero_flag (zero_flag),
    .irq       (irq),
    .fetch_req (fetch_req),
    .load_pc   (load_pc),
    .inc_pc    (inc_pc),
    .pc_in     (pc_in),
    .in_isr    (in_isr),
    .halted    (halted),
    .stack_err (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model driven by the sequencer strobes.
  always @(posedge clk or posedge reset) begin
    if (reset)        pc <= pc_preset;
    else if (load_pc) pc <= pc_in;
    else if (inc_pc)  pc <= pc + 8'd1;
  end

  assign instr   = prog_instr[pc];
  assign operand = prog_op[pc];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog_instr[i] = 8'h00;
      prog_op[i]    = 8'h00;
    end
  endtask

  task automatic do_reset(input logic [7:0] preset);
    pc_preset = preset;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  // Runs one instruction from FETCH and reports the EXEC-cycle strobes.
  task automatic run_instr(output logic l, output logic i, output logic [7:0] pin);
    step();
    step();
    l   = load_pc;
    i   = inc_pc;
    pin = pc_in;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if ({fetch_req, load_pc, inc_pc, in_isr, halted, stack_err} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 000000", {fetch_req, load_pc, inc_pc, in_isr, halted, stack_err});
    end
    total++; if (pc_in !== 8'h00) begin bad++; $display("FAIL reset_pc_in: got %h want 00", pc_in); end
    step();
    reset = 1'b0;
    #1;
    total++; if (fetch_req !== 1'b1) begin bad++; $display("FAIL reset_fetch: got %b want 1", fetch_req); end
    $display("reset: fetch_req=%b halted=%b", fetch_req, halted);
  endtask

  task automatic test_sequential();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    do_reset(8'h00);
    for (int k = 0; k < 3; k++) begin
      run_instr(l, i, pin);
      total++; if (i !== 1'b1 || l !== 1'b0) begin bad++; $display("FAIL seq_strobe%0d: got load=%b inc=%b want load=0 inc=1", k, l, i); end
      total++; if (pc !== 8'(k + 1)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", k, pc, 8'(k + 1)); end
      $display("seq %0d: inc=%b pc=%h", k, i, pc);
    end
  endtask

  task automatic test_branch();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    prog_instr[8'h00] = 8'h20; prog_op[8'h00] = 8'h40;
    prog_instr[8'h40] = 8'h40; prog_op[8'h40] = 8'h20;
    prog_instr[8'h41] = 8'h40; prog_op[8'h41] = 8'h20;
    do_reset(8'h00);
    run_instr(l, i, pin);
    total++; if (l !== 1'b1 || i !== 1'b0 || pin !== 8'h40) begin bad++; $display("FAIL jmp: got load=%b inc=%b pc_in=%h want 1 0 40", l, i, pin); end
    $display("jmp: pc_in=%h pc=%h", pin, pc);
    zero_flag = 1'b0;
    run_instr(l, i, pin);
    total++; if (l !== 1'b0 || i !== 1'b1) begin bad++; $display("FAIL jz_not_taken: got load=%b inc=%b want 0 1", l, i); end
    total++; if (pc !== 8'h41) begin bad++; $display("FAIL jz_nt_pc: got %h want 41", pc); end
    $display("jz z=0: inc=%b pc=%h", i, pc);
    zero_flag = 1'b1;
    step();
    step();
    zero_flag = 1'b0;
    l = load_pc; pin = pc_in;
    step();
    total++; if (l !== 1'b1 || pin !== 8'h20) begin bad++; $display("FAIL jz_taken: got load=%b pc_in=%h want 1 20", l, pin); end
    $display("jz z=1: load=%b pc_in=%h", l, pin);
  endtask

  task automatic test_call_ret();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    prog_instr[8'h10] = 8'h60; prog_op[8'h10] = 8'h80;
    prog_instr[8'h80] = 8'h80;
    prog_instr[8'h11] = 8'h80;
    do_reset(8'h10);
    run_instr(l, i, pin);
    total++; if (l !== 1'b1 || pin !== 8'h80) begin bad++; $display("FAIL call: got load=%b pc_in=%h want 1 80", l, pin); end
    $display("call: pc_in=%h", pin);
    run_instr(l, i, pin);
    total++; if (l !== 1'b1 || pin !== 8'h11) begin bad++; $display("FAIL ret: got load=%b pc_in=%h want 1 11", l, pin); end
    total++; if (pc !== 8'h11) begin bad++; $display("FAIL ret_pc: got %h want 11", pc); end
    $display("ret: pc_in=%h pc=%h", pin, pc);
    step();
    step();
    total++; if (stack_err !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL ret_empty_after: got err=%b halted=%b want 1 1", stack_err, halted); end
    clear_prog();
    prog_instr[8'hFF] = 8'h60; prog_op[8'hFF] = 8'h30;
    prog_instr[8'h30] = 8'h80;
    do_reset(8'hFF);
    run_instr(l, i, pin);
    run_instr(l, i, pin);
    total++; if (l !== 1'b1 || pin !== 8'h00 || pc !== 8'h00) begin bad++; $display("FAIL call_wrap: got load=%b pc_in=%h pc=%h want 1 00 00", l, pin, pc); end
    $display("call wrap: ret pc_in=%h", pin);
  endtask

  task automatic test_stack_limits();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    for (int k = 0; k < 5; k++) begin
      prog_instr[k] = 8'h60;
      prog_op[k]    = 8'(k + 1);
    end
    do_reset(8'h00);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) irq = 1'b1;
      run_instr(l, i, pin);
      total++; if (l !== 1'b1 || pin !== 8'(k + 1)) begin bad++; $display("FAIL nest_call%0d: got load=%b pc_in=%h want 1 %h", k, l, pin, 8'(k + 1)); end
      $display("nested call %0d: pc_in=%h", k, pin);
    end
    total++; if (fetch_req !== 1'b1 || in_isr !== 1'b0 || stack_err !== 1'b0) begin
      bad++; $display("FAIL irq_deferred: got fetch=%b isr=%b err=%b want 1 0 0", fetch_req, in_isr, stack_err);
    end
    irq = 1'b0;
    step();
    step();
    total++; if (stack_err !== 1'b1 || halted !== 1'b1 || load_pc !== 1'b0 || inc_pc !== 1'b0) begin
      bad++; $display("FAIL overflow: got err=%b halted=%b load=%b inc=%b want 1 1 0 0", stack_err, halted, load_pc, inc_pc);
    end
    step();
    step();
    total++; if (halted !== 1'b1 || fetch_req !== 1'b0 || load_pc !== 1'b0) begin bad++; $display("FAIL halt_hold: got halted=%b fetch=%b load=%b want 1 0 0", halted, fetch_req, load_pc); end
    $display("overflow: err=%b halted=%b", stack_err, halted);
    clear_prog();
    prog_instr[8'h00] = 8'h80;
    do_reset(8'h00);
    total++; if (stack_err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", stack_err); end
    step();
    step();
    total++; if (stack_err !== 1'b1 || halted !== 1'b1 || load_pc !== 1'b0) begin bad++; $display("FAIL underflow: got err=%b halted=%b load=%b want 1 1 0", stack_err, halted, load_pc); end
    $display("underflow: err=%b halted=%b", stack_err, halted);
  endtask

  task automatic test_irq();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    prog_instr[8'hF1] = 8'h80;
    do_reset(8'h05);
    irq = 1'b1;
    step();
    step();
    total++; if (inc_pc !== 1'b1) begin bad++; $display("FAIL irq_exec: got inc=%b want 1", inc_pc); end
    step();
    total++; if (load_pc !== 1'b1 || pc_in !== 8'hF0 || pc !== 8'h06) begin bad++; $display("FAIL irq_entry: got load=%b pc_in=%h pc=%h want 1 f0 06", load_pc, pc_in, pc); end
    step();
    total++; if (in_isr !== 1'b1 || pc !== 8'hF0) begin bad++; $display("FAIL irq_isr: got isr=%b pc=%h want 1 f0", in_isr, pc); end
    $display("irq entry: in_isr=%b pc=%h", in_isr, pc);
    run_instr(l, i, pin);
    total++; if (fetch_req !== 1'b1 || load_pc !== 1'b0 || pc !== 8'hF1) begin bad++; $display("FAIL irq_ignored: got fetch=%b load=%b pc=%h want 1 0 f1", fetch_req, load_pc, pc); end
    irq = 1'b0;
    run_instr(l, i, pin);
    total++; if (l !== 1'b1 || pin !== 8'h06 || pc !== 8'h06) begin bad++; $display("FAIL isr_ret: got load=%b pc_in=%h pc=%h want 1 06 06", l, pin, pc); end
    total++; if (in_isr !== 1'b0) begin bad++; $display("FAIL isr_clear: got %b want 0", in_isr); end
    $display("isr return: pc=%h in_isr=%b", pc, in_isr);
  endtask

  task automatic test_stall();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    do_reset(8'h00);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (fetch_req !== 1'b1 || load_pc !== 1'b0 || inc_pc !== 1'b0) begin bad++; $display("FAIL stall%0d: got fetch=%b load=%b inc=%b want 1 0 0", k, fetch_req, load_pc, inc_pc); end
    end
    mem_ready = 1'b1;
    run_instr(l, i, pin);
    total++; if (i !== 1'b1 || pc !== 8'h01) begin bad++; $display("FAIL stall_resume: got inc=%b pc=%h want 1 01", i, pc); end
    $display("stall: resumed pc=%h", pc);
  endtask

  task automatic test_reset_in_exec();
    logic l, i;
    logic [7:0] pin;
    clear_prog();
    prog_instr[8'h00] = 8'h20; prog_op[8'h00] = 8'h40;
    do_reset(8'h00);
    step();
    step();
    total++; if (load_pc !== 1'b1) begin bad++; $display("FAIL exec_pre: got load=%b want 1", load_pc); end
    reset = 1'b1;
    #1;
    total++; if ({fetch_req, load_pc, inc_pc, halted} !== 4'b0 || pc_in !== 8'h00) begin
      bad++; $display("FAIL reset_exec: got %b pc_in=%h want 0000 00", {fetch_req, load_pc, inc_pc, halted}, pc_in);
    end
    step();
    reset = 1'b0;
    #1;
    total++; if (fetch_req !== 1'b1 || pc !== 8'h00) begin bad++; $display("FAIL reset_release: got fetch=%b pc=%h want 1 00", fetch_req, pc); end
    run_instr(l, i, pin);
    total++; if (l !== 1'b1 || pin !== 8'h40) begin bad++; $display("FAIL reset_rerun: got load=%b pc_in=%h want 1 40", l, pin); end
    $display("reset in exec: rerun pc_in=%h", pin);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    pc_preset = 8'h00;
    mem_ready = 1'b1;
    zero_flag = 1'b0;
    irq       = 1'b0;
    clear_prog();
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_stack_limits();
    test_irq();
    test_stall();
    test_reset_in_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
